// File: rtl/timer_bcd_countdown.sv
// MM:SS BCD countdown core: preset load, start/pause/clear control, 1 s prescaler, expiry pulse.
// Latency: every control input acts on the next rising clk edge; all outputs come straight from flops.
// Backpressure: none; control pulses are sampled every cycle, and a rejected load is flagged on load_err.
module timer_bcd_countdown #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_min_D1,
   input  logic [3:0] load_min_D0,
   input  logic [3:0] load_sec_D1,
   input  logic [3:0] load_sec_D0,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] min_D1,
   output logic [3:0] min_D0,
   output logic [3:0] sec_D1,
   output logic [3:0] sec_D0,
   output logic       running,
   output logic       tick,
   output logic       expired,
   output logic       load_err
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_nxt;

   logic [3:0] min_d1_nxt;
   logic [3:0] min_d0_nxt;
   logic [3:0] sec_d1_nxt;
   logic [3:0] sec_d0_nxt;
   logic       tick_nxt;
   logic       expired_nxt;
   logic       load_err_nxt;

   // decremented copy of the current digits (BCD borrow chain)
   logic [3:0] dec_min_d1;
   logic [3:0] dec_min_d0;
   logic [3:0] dec_sec_d1;
   logic [3:0] dec_sec_d0;
   logic       dec_zero;

   logic load_ok;
   logic load_act;
   logic load_acc;
   logic load_rej;
   logic digits_zero;
   logic tick_now;
   logic start_ok;

   // seconds tens is capped at 5 so the preset is always a legal MM:SS value
   assign load_ok = (load_min_D1 <= 4'd9) && (load_min_D0 <= 4'd9) &&
                    (load_sec_D1 <= 4'd5) && (load_sec_D0 <= 4'd9);

   // load is swallowed silently while running; clear always takes precedence
   assign load_act = load && !clear && (state != ST_RUN);
   assign load_acc = load_act && load_ok;
   assign load_rej = load_act && !load_ok;

   assign digits_zero = (min_D1 == 4'd0) && (min_D0 == 4'd0) &&
                        (sec_D1 == 4'd0) && (sec_D0 == 4'd0);

   // terminal prescaler count in RUN: the digits step down on this edge
   assign tick_now = !clear && (state == ST_RUN) && (presc == PRESC_MAX);

   // a start from IDLE needs something to count down
   assign start_ok = !clear && !load_act && (state == ST_IDLE) && start && !digits_zero;

   assign running = (state == ST_RUN);

   // BCD borrow chain; 00:00 maps to itself so the count never wraps to 99:59
   always_comb begin
      dec_min_d1 = min_D1;
      dec_min_d0 = min_D0;
      dec_sec_d1 = sec_D1;
      dec_sec_d0 = sec_D0;
      if (!digits_zero) begin
         if (sec_D0 != 4'd0) begin
            dec_sec_d0 = sec_D0 - 4'd1;
         end else begin
            dec_sec_d0 = 4'd9;
            if (sec_D1 != 4'd0) begin
               dec_sec_d1 = sec_D1 - 4'd1;
            end else begin
               dec_sec_d1 = 4'd5;
               if (min_D0 != 4'd0) begin
                  dec_min_d0 = min_D0 - 4'd1;
               end else begin
                  dec_min_d0 = 4'd9;
                  dec_min_d1 = min_D1 - 4'd1;
               end
            end
         end
      end
   end

   assign dec_zero = (dec_min_d1 == 4'd0) && (dec_min_d0 == 4'd0) &&
                     (dec_sec_d1 == 4'd0) && (dec_sec_d0 == 4'd0);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: clear > load > start/pause; expiry beats a same-cycle pause
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else if (load_act) begin
         if (load_ok) begin
            state_nxt = ST_IDLE;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (tick_now && dec_zero) begin
                  state_nxt = ST_DONE;
               end else if (pause) begin
                  state_nxt = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_DONE: begin
               state_nxt = ST_DONE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // output/datapath next values: digits, prescaler and the three pulses
   always_comb begin
      min_d1_nxt   = min_D1;
      min_d0_nxt   = min_D0;
      sec_d1_nxt   = sec_D1;
      sec_d0_nxt   = sec_D0;
      presc_nxt    = presc;
      tick_nxt     = 1'b0;
      expired_nxt  = 1'b0;
      load_err_nxt = 1'b0;
      if (clear) begin
         min_d1_nxt = 4'd0;
         min_d0_nxt = 4'd0;
         sec_d1_nxt = 4'd0;
         sec_d0_nxt = 4'd0;
         presc_nxt  = '0;
      end else if (load_acc) begin
         min_d1_nxt = load_min_D1;
         min_d0_nxt = load_min_D0;
         sec_d1_nxt = load_sec_D1;
         sec_d0_nxt = load_sec_D0;
         presc_nxt  = '0;
      end else if (load_rej) begin
         load_err_nxt = 1'b1;
      end else if (start_ok) begin
         presc_nxt = '0;
      end else if (state == ST_RUN) begin
         // a pause in this cycle still counts: the RUN cycle itself is timed
         if (tick_now) begin
            presc_nxt   = '0;
            min_d1_nxt  = dec_min_d1;
            min_d0_nxt  = dec_min_d0;
            sec_d1_nxt  = dec_sec_d1;
            sec_d0_nxt  = dec_sec_d0;
            tick_nxt    = 1'b1;
            expired_nxt = dec_zero;
         end else begin
            presc_nxt = presc + PW'(1);
         end
      end
   end

   // datapath and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_D1   <= 4'd0;
         min_D0   <= 4'd0;
         sec_D1   <= 4'd0;
         sec_D0   <= 4'd0;
         presc    <= '0;
         tick     <= 1'b0;
         expired  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         min_D1   <= min_d1_nxt;
         min_D0   <= min_d0_nxt;
         sec_D1   <= sec_d1_nxt;
         sec_D0   <= sec_d0_nxt;
         presc    <= presc_nxt;
         tick     <= tick_nxt;
         expired  <= expired_nxt;
         load_err <= load_err_nxt;
      end
   end

endmodule
